// File: rtl/map_scroll_ctrl_pkg.sv
// Shared constants for the map viewport/camera controller: default geometry,
// FSM state encoding and the blanking colour.
package map_pkg;

    localparam int DEF_MAP_WIDTH_X = 640;
    localparam int DEF_MAP_WIDTH_Y = 960;
    localparam int DEF_VIEW_X0     = 0;
    localparam int DEF_VIEW_Y0     = 0;
    localparam int DEF_VIEW_W      = 640;
    localparam int DEF_VIEW_H      = 480;
    localparam int DEF_SCROLL_STEP = 4;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_PENDING = 2'd1;
    localparam logic [1:0] S_MOVING  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE    = S_IDLE,
        ST_PENDING = S_PENDING,
        ST_MOVING  = S_MOVING
    } cam_state_t;

    localparam logic [11:0] RGB_BLANK = 12'h000;

    // Limit a requested camera coordinate so the viewport stays inside the map.
    function automatic logic [9:0] clamp_coord(input logic [9:0] req, input logic [9:0] max_val);
        return (req > max_val) ? max_val : req;
    endfunction

endpackage

// File: rtl/map_scroll_ctrl_axis_step.sv
// One-axis camera step: moves cam toward target by at most STEP pixels and
// flags when the resulting position lands on the target.
module scroll_axis_step #(
    parameter int STEP = 4
) (
    input  logic [9:0] cam,
    input  logic [9:0] target,
    output logic [9:0] next_cam,
    output logic       reached
);

    localparam logic signed [10:0] STEP_S   = 11'(STEP);
    localparam logic        [9:0]  STEP_U10 = 10'(STEP);

    logic signed [10:0] diff;
    logic signed [10:0] mag;

    always_comb begin
        diff = $signed({1'b0, target}) - $signed({1'b0, cam});
        mag  = (diff < 0) ? -diff : diff;
        if (mag <= STEP_S) begin
            next_cam = target;
        end else if (diff < 0) begin
            next_cam = cam - STEP_U10;
        end else begin
            next_cam = cam + STEP_U10;
        end
        reached = (next_cam == target);
    end

endmodule

// File: rtl/map_scroll_ctrl.sv
// Viewport controller: maps screen pixels to map coordinates through a camera
// offset that scrolls toward requested targets only on frame boundaries.
module map_scroll_ctrl
    import map_pkg::*;
#(
    parameter int MAP_WIDTH_X = DEF_MAP_WIDTH_X,
    parameter int MAP_WIDTH_Y = DEF_MAP_WIDTH_Y,
    parameter int VIEW_X0     = DEF_VIEW_X0,
    parameter int VIEW_Y0     = DEF_VIEW_Y0,
    parameter int VIEW_W      = DEF_VIEW_W,
    parameter int VIEW_H      = DEF_VIEW_H,
    parameter int SCROLL_STEP = DEF_SCROLL_STEP
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [9:0]  pixel_x,
    input  logic [9:0]  pixel_y,
    input  logic        video_on,
    input  logic        frame_tick,
    input  logic        cam_req_valid,
    output logic        cam_req_ready,
    input  logic [9:0]  cam_req_x,
    input  logic [9:0]  cam_req_y,
    output logic [9:0]  map_x,
    output logic [9:0]  map_y,
    output logic        map_on,
    input  logic [11:0] map_rgb,
    output logic [11:0] pix_rgb,
    output logic [9:0]  cam_x,
    output logic [9:0]  cam_y,
    output logic        cam_busy
);

    localparam logic [9:0]  CAM_MAX_X = 10'(MAP_WIDTH_X - VIEW_W);
    localparam logic [9:0]  CAM_MAX_Y = 10'(MAP_WIDTH_Y - VIEW_H);
    localparam logic [10:0] VX0_W     = 11'(VIEW_X0);
    localparam logic [10:0] VY0_W     = 11'(VIEW_Y0);
    localparam logic [10:0] VW_W      = 11'(VIEW_W);
    localparam logic [10:0] VH_W      = 11'(VIEW_H);
    localparam logic [9:0]  VX0_10    = 10'(VIEW_X0);
    localparam logic [9:0]  VY0_10    = 10'(VIEW_Y0);

    cam_state_t state;
    logic [9:0] shadow_x, shadow_y;
    logic [9:0] target_x, target_y;
    logic [9:0] step_tgt_x, step_tgt_y;
    logic [9:0] next_x, next_y;
    logic       reached_x, reached_y;
    logic       reached;
    logic       accept;
    logic [9:0] req_x_clamped, req_y_clamped;

    logic [10:0] rel_x, rel_y;
    logic        in_view;
    logic        video_on_d1;

    assign accept        = cam_req_valid & cam_req_ready;
    assign req_x_clamped = clamp_coord(cam_req_x, CAM_MAX_X);
    assign req_y_clamped = clamp_coord(cam_req_y, CAM_MAX_Y);

    // While PENDING the target register is not loaded yet, so step toward the shadow.
    assign step_tgt_x = (state == ST_PENDING) ? shadow_x : target_x;
    assign step_tgt_y = (state == ST_PENDING) ? shadow_y : target_y;
    assign reached    = reached_x & reached_y;

    scroll_axis_step #(.STEP(SCROLL_STEP)) u_step_x (
        .cam      (cam_x),
        .target   (step_tgt_x),
        .next_cam (next_x),
        .reached  (reached_x)
    );

    scroll_axis_step #(.STEP(SCROLL_STEP)) u_step_y (
        .cam      (cam_y),
        .target   (step_tgt_y),
        .next_cam (next_y),
        .reached  (reached_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            shadow_x      <= '0;
            shadow_y      <= '0;
            target_x      <= '0;
            target_y      <= '0;
            cam_x         <= '0;
            cam_y         <= '0;
            cam_req_ready <= 1'b1;
            cam_busy      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        shadow_x      <= req_x_clamped;
                        shadow_y      <= req_y_clamped;
                        state         <= ST_PENDING;
                        cam_req_ready <= 1'b0;
                        cam_busy      <= 1'b1;
                    end
                end
                ST_PENDING: begin
                    if (frame_tick) begin
                        target_x      <= shadow_x;
                        target_y      <= shadow_y;
                        cam_x         <= next_x;
                        cam_y         <= next_y;
                        cam_req_ready <= 1'b1;
                        if (reached) begin
                            state    <= ST_IDLE;
                            cam_busy <= 1'b0;
                        end else begin
                            state    <= ST_MOVING;
                        end
                    end
                end
                ST_MOVING: begin
                    if (frame_tick) begin
                        cam_x <= next_x;
                        cam_y <= next_y;
                    end
                    // A new request wins over arrival; the step above still used the old target.
                    if (accept) begin
                        shadow_x      <= req_x_clamped;
                        shadow_y      <= req_y_clamped;
                        state         <= ST_PENDING;
                        cam_req_ready <= 1'b0;
                    end else if (frame_tick && reached) begin
                        state    <= ST_IDLE;
                        cam_busy <= 1'b0;
                    end
                end
                default: begin
                    state         <= ST_IDLE;
                    cam_req_ready <= 1'b1;
                    cam_busy      <= 1'b0;
                end
            endcase
        end
    end

    // Out-of-range pixels wrap to large unsigned values and fail the window compare.
    always_comb begin
        rel_x   = {1'b0, pixel_x} - VX0_W;
        rel_y   = {1'b0, pixel_y} - VY0_W;
        in_view = video_on && (rel_x < VW_W) && (rel_y < VH_W);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            map_x       <= '0;
            map_y       <= '0;
            map_on      <= 1'b0;
            video_on_d1 <= 1'b0;
            pix_rgb     <= RGB_BLANK;
        end else begin
            map_x       <= in_view ? (pixel_x - VX0_10 + cam_x) : 10'd0;
            map_y       <= in_view ? (pixel_y - VY0_10 + cam_y) : 10'd0;
            map_on      <= in_view;
            video_on_d1 <= video_on;
            pix_rgb     <= video_on_d1 ? map_rgb : RGB_BLANK;
        end
    end

endmodule

// File: tb/tb_map_scroll_ctrl.sv
// Self-checking bench for map_scroll_ctrl: reset, scrolling, clamping,
// pixel pipeline vectors and request/frame_tick collisions.
module tb_map_scroll_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  pixel_x, pixel_y;
    logic        video_on, frame_tick;
    logic        cam_req_valid, cam_req_ready;
    logic [9:0]  cam_req_x, cam_req_y;
    logic [9:0]  map_x, map_y;
    logic        map_on;
    logic [11:0] map_rgb, pix_rgb;
    logic [9:0]  cam_x, cam_y;
    logic        cam_busy;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [9:0]  px;
        logic [9:0]  py;
        logic        vo;
        logic [11:0] rgb;
        logic [9:0]  ex;
        logic [9:0]  ey;
        logic        eon;
        logic [11:0] epix;
    } pix_vec_t;

    pix_vec_t vecs[7];

    always #5 clk = ~clk;

    map_scroll_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pixel_x       (pixel_x),
        .pixel_y       (pixel_y),
        .video_on      (video_on),
        .frame_tick    (frame_tick),
        .cam_req_valid (cam_req_valid),
        .cam_req_ready (cam_req_ready),
        .cam_req_x     (cam_req_x),
        .cam_req_y     (cam_req_y),
        .map_x         (map_x),
        .map_y         (map_y),
        .map_on        (map_on),
        .map_rgb       (map_rgb),
        .pix_rgb       (pix_rgb),
        .cam_x         (cam_x),
        .cam_y         (cam_y),
        .cam_busy      (cam_busy)
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [9:0] rx, input logic [9:0] ry,
                                 input logic tick);
        cam_req_valid = valid;
        cam_req_x     = rx;
        cam_req_y     = ry;
        frame_tick    = tick;
        @(posedge clk);
        #1;
        cam_req_valid = 1'b0;
        frame_tick    = 1'b0;
    endtask

    task automatic tickFrame();
        applyStimulus(1'b0, 10'd0, 10'd0, 1'b1);
    endtask

    task automatic scrollUntilIdle(input int max_ticks, output int n);
        n = 0;
        while (cam_busy && n < max_ticks) begin
            tickFrame();
            n++;
        end
        if (cam_busy) checkOutput("scroll_timeout_busy", int'(cam_busy), 0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;

        vecs[0] = '{10'd5,   10'd7,   1'b1, 12'hABC, 10'd5,   10'd107, 1'b1, 12'hABC};
        vecs[1] = '{10'd5,   10'd7,   1'b0, 12'h123, 10'd0,   10'd0,   1'b0, 12'h000};
        vecs[2] = '{10'd639, 10'd479, 1'b1, 12'hFFF, 10'd639, 10'd579, 1'b1, 12'hFFF};
        vecs[3] = '{10'd640, 10'd10,  1'b1, 12'h111, 10'd0,   10'd0,   1'b0, 12'h111};
        vecs[4] = '{10'd10,  10'd480, 1'b1, 12'h222, 10'd0,   10'd0,   1'b0, 12'h222};
        vecs[5] = '{10'd0,   10'd0,   1'b1, 12'h0F0, 10'd0,   10'd100, 1'b1, 12'h0F0};
        vecs[6] = '{10'd100, 10'd400, 1'b1, 12'h5A5, 10'd100, 10'd500, 1'b1, 12'h5A5};

        rst_n         = 1'b0;
        pixel_x       = 10'd3;
        pixel_y       = 10'd3;
        video_on      = 1'b1;
        frame_tick    = 1'b0;
        cam_req_valid = 1'b0;
        cam_req_x     = '0;
        cam_req_y     = '0;
        map_rgb       = 12'hFFF;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_map_x", int'(map_x), 0);
        checkOutput("rst_map_y", int'(map_y), 0);
        checkOutput("rst_map_on", int'(map_on), 0);
        checkOutput("rst_pix_rgb", int'(pix_rgb), 0);
        checkOutput("rst_cam_x", int'(cam_x), 0);
        checkOutput("rst_cam_y", int'(cam_y), 0);
        checkOutput("rst_ready", int'(cam_req_ready), 1);
        checkOutput("rst_busy", int'(cam_busy), 0);
        video_on = 1'b0;
        rst_n    = 1'b1;

        // Scroll y from 0 to 100 in steps of 4, holding between ticks.
        applyStimulus(1'b1, 10'd0, 10'd100, 1'b0);
        checkOutput("t2_ready_pending", int'(cam_req_ready), 0);
        checkOutput("t2_busy_pending", int'(cam_busy), 1);
        checkOutput("t2_cam_before_tick", int'(cam_y), 0);
        for (int k = 1; k <= 25; k++) begin
            tickFrame();
            checkOutput("t2_cam_y", int'(cam_y), 4 * k);
            checkOutput("t2_busy", int'(cam_busy), (k < 25) ? 1 : 0);
            applyStimulus(1'b0, 10'd0, 10'd0, 1'b0);
            checkOutput("t2_cam_y_hold", int'(cam_y), 4 * k);
        end
        checkOutput("t2_cam_x", int'(cam_x), 0);

        // Pixel pipeline vectors with camera at (0,100).
        for (int i = 0; i < 7; i++) begin
            pixel_x  = vecs[i].px;
            pixel_y  = vecs[i].py;
            video_on = vecs[i].vo;
            map_rgb  = vecs[i].rgb;
            @(posedge clk);
            #1;
            checkOutput($sformatf("vec%0d_map_x", i), int'(map_x), int'(vecs[i].ex));
            checkOutput($sformatf("vec%0d_map_y", i), int'(map_y), int'(vecs[i].ey));
            checkOutput($sformatf("vec%0d_map_on", i), int'(map_on), int'(vecs[i].eon));
            @(posedge clk);
            #1;
            checkOutput($sformatf("vec%0d_pix_rgb", i), int'(pix_rgb), int'(vecs[i].epix));
        end
        video_on = 1'b0;
        pixel_x  = '0;
        pixel_y  = '0;
        @(posedge clk);
        #1;

        // Clamp: (700,900) becomes (0,480).
        applyStimulus(1'b1, 10'd700, 10'd900, 1'b0);
        checkOutput("t3_ready", int'(cam_req_ready), 0);
        scrollUntilIdle(200, n);
        checkOutput("t3_ticks", n, 95);
        checkOutput("t3_cam_y", int'(cam_y), 480);
        checkOutput("t3_cam_x", int'(cam_x), 0);
        tickFrame();
        checkOutput("t3_cam_y_stays", int'(cam_y), 480);
        checkOutput("t3_busy_idle", int'(cam_busy), 0);

        // Accept in IDLE together with frame_tick: no move until the next tick.
        applyStimulus(1'b1, 10'd0, 10'd460, 1'b1);
        checkOutput("t6_cam_unchanged", int'(cam_y), 480);
        checkOutput("t6_busy", int'(cam_busy), 1);
        checkOutput("t6_ready", int'(cam_req_ready), 0);
        tickFrame();
        checkOutput("t6_first_step", int'(cam_y), 476);
        scrollUntilIdle(20, n);
        checkOutput("t6_ticks", n, 4);
        checkOutput("t6_final", int'(cam_y), 460);

        // Asynchronous reset in the middle of a scroll.
        applyStimulus(1'b1, 10'd0, 10'd0, 1'b0);
        tickFrame();
        tickFrame();
        checkOutput("t1_mid_cam_y", int'(cam_y), 452);
        rst_n = 1'b0;
        #1;
        checkOutput("t1_cam_y", int'(cam_y), 0);
        checkOutput("t1_busy", int'(cam_busy), 0);
        checkOutput("t1_ready", int'(cam_req_ready), 1);
        checkOutput("t1_map_on", int'(map_on), 0);
        checkOutput("t1_pix_rgb", int'(pix_rgb), 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Retarget from y=100 to y=20 during MOVING at cam_y=40.
        applyStimulus(1'b1, 10'd0, 10'd100, 1'b0);
        for (int k = 1; k <= 10; k++) tickFrame();
        checkOutput("t5_cam_y_40", int'(cam_y), 40);
        checkOutput("t5_ready_moving", int'(cam_req_ready), 1);
        applyStimulus(1'b1, 10'd0, 10'd20, 1'b1);
        checkOutput("t5_cam_y_44", int'(cam_y), 44);
        checkOutput("t5_ready_pending", int'(cam_req_ready), 0);
        checkOutput("t5_busy", int'(cam_busy), 1);
        tickFrame();
        checkOutput("t5_cam_y_back_40", int'(cam_y), 40);
        checkOutput("t5_ready_again", int'(cam_req_ready), 1);
        scrollUntilIdle(20, n);
        checkOutput("t5_ticks", n, 5);
        checkOutput("t5_final", int'(cam_y), 20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
